// File: rtl/mul_acc_pkg.sv
// Shared definitions for the MUL8 dot-product controller: state encoding and
// datapath widths.
package mul_acc_pkg;

  localparam int ACC_W   = 24;
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    S_WAIT_IN = 2'b00,
    S_MUL     = 2'b01,
    S_OUT     = 2'b10
  } state_t;

endpackage

// File: rtl/mul_accumulator.sv
// Drives operand pairs onto an external combinational 8x8 multiplier and
// accumulates N products into a dot-product sum handed out over valid/ready.
module mul_accumulator
  import mul_acc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       mul_x,
  output logic [7:0]       mul_y,
  input  logic [15:0]      mul_m,
  output logic [ACC_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t             state, state_nxt;
  logic [7:0]         x_q, x_nxt;
  logic [7:0]         y_q, y_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [COUNT_W-1:0] count, count_nxt;

  function automatic logic [ACC_W-1:0] zext_prod(input logic [15:0] p);
    return ACC_W'(p);
  endfunction

  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    acc_nxt   = acc;
    count_nxt = count;
    case (state)
      S_WAIT_IN: begin
        if (in_valid) begin
          x_nxt     = in_x;
          y_nxt     = in_y;
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        // Operands have been stable since the accept edge, so mul_m is settled here.
        acc_nxt = acc + zext_prod(mul_m);
        if (count == COUNT_W'(N - 1)) begin
          state_nxt = S_OUT;
        end else begin
          count_nxt = count + COUNT_W'(1);
          state_nxt = S_WAIT_IN;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_nxt   = '0;
          count_nxt = '0;
          state_nxt = S_WAIT_IN;
        end
      end
      default: state_nxt = S_WAIT_IN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= S_WAIT_IN;
      x_q   <= '0;
      y_q   <= '0;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
    end
  end

  assign mul_x     = x_q;
  assign mul_y     = y_q;
  assign sum       = acc;
  assign in_ready  = (state == S_WAIT_IN);
  assign out_valid = (state == S_OUT);

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: an N=4 instance covers grouping, stalls,
// backpressure and mid-group reset; an N=1 instance covers single-pair groups.
module tb_mul_accumulator;

  logic        clock = 1'b0;
  logic        reset_;
  logic [7:0]  in_x, in_y;
  logic        in_valid, in_ready;
  logic [7:0]  mul_x, mul_y;
  logic [15:0] mul_m;
  logic [23:0] sum;
  logic        out_valid, out_ready;

  logic [7:0]  b_in_x, b_in_y;
  logic        b_in_valid, b_in_ready;
  logic [7:0]  b_mul_x, b_mul_y;
  logic [15:0] b_mul_m;
  logic [23:0] b_sum;
  logic        b_out_valid, b_out_ready;

  int total = 0;
  int bad   = 0;
  logic [7:0] px [4];
  logic [7:0] py [4];
  int cyc;

  always #5 clock = ~clock;

  // MUL8 stand-ins at the level above the controller
  assign mul_m   = 16'(mul_x) * 16'(mul_y);
  assign b_mul_m = 16'(b_mul_x) * 16'(b_mul_y);

  mul_accumulator #(.N(4)) dut4 (
    .clock(clock), .reset_(reset_),
    .in_x(in_x), .in_y(in_y), .in_valid(in_valid), .in_ready(in_ready),
    .mul_x(mul_x), .mul_y(mul_y), .mul_m(mul_m),
    .sum(sum), .out_valid(out_valid), .out_ready(out_ready)
  );

  mul_accumulator #(.N(1)) dut1 (
    .clock(clock), .reset_(reset_),
    .in_x(b_in_x), .in_y(b_in_y), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mul_x(b_mul_x), .mul_y(b_mul_y), .mul_m(b_mul_m),
    .sum(b_sum), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pairs(input logic [7:0] x0, y0, x1, y1, x2, y2, x3, y3);
    px[0] = x0; py[0] = y0; px[1] = x1; py[1] = y1;
    px[2] = x2; py[2] = y2; px[3] = x3; py[3] = y3;
  endtask

  // cyc_o: rising edges from the first accept edge (counted as 1) to the
  // edge on which out_valid rises.
  task automatic feed_group(input int stall_at, input int stall_len, output int cyc_o);
    int budget;
    int c;
    c = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == stall_at) begin
        in_valid = 1'b0;
        budget = 0;
        while (!in_ready && budget < 20) begin step(); c++; budget++; end
        repeat (stall_len) begin step(); c++; end
      end
      in_x = px[k]; in_y = py[k]; in_valid = 1'b1;
      budget = 0;
      while (!in_ready && budget < 20) begin step(); c++; budget++; end
      if (k == 0) c = 0;
      step(); c++;
      chk("mul_x_pair", {24'd0, mul_x}, {24'd0, px[k]});
      chk("mul_y_pair", {24'd0, mul_y}, {24'd0, py[k]});
    end
    in_valid = 1'b0;
    budget = 0;
    while (!out_valid && budget < 40) begin step(); c++; budget++; end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    cyc_o = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ = 1'b0;
    in_x = 8'd0; in_y = 8'd0; in_valid = 1'b0; out_ready = 1'b1;
    b_in_x = 8'd0; b_in_y = 8'd0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mul_x",     {24'd0, mul_x},     32'd0);
    chk("rst_mul_y",     {24'd0, mul_y},     32'd0);
    chk("rst_sum",       {8'd0, sum},        32'd0);
    reset_ = 1'b1;
    step();

    // basic group, out_ready high: one-cycle out_valid
    set_pairs(8'd5, 8'd28, 8'd5, 8'd35, 8'd5, 8'd42, 8'd5, 8'd49);
    feed_group(-1, 0, cyc);
    chk("basic_latency", cyc, 32'd8);
    chk("basic_sum", {8'd0, sum}, 32'd770);
    step();
    chk("basic_ov_drop", {31'd0, out_valid}, 32'd0);
    chk("basic_acc_clr", {8'd0, sum}, 32'd0);
    chk("basic_in_ready", {31'd0, in_ready}, 32'd1);

    // worst-case operands
    set_pairs(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    feed_group(-1, 0, cyc);
    chk("worst_latency", cyc, 32'd8);
    chk("worst_sum", {8'd0, sum}, 32'h0003F804);
    step();

    // three idle cycles between pairs 2 and 3
    set_pairs(8'd5, 8'd28, 8'd5, 8'd35, 8'd5, 8'd42, 8'd5, 8'd49);
    feed_group(2, 3, cyc);
    chk("stall_latency", cyc, 32'd11);
    chk("stall_sum", {8'd0, sum}, 32'd770);
    step();

    // consumer backpressure; a fifth pair is offered while the sum is held
    out_ready = 1'b0;
    feed_group(-1, 0, cyc);
    in_x = 8'd10; in_y = 8'd11; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum_hold", {8'd0, sum}, 32'd770);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    chk("bp_not_taken", {24'd0, mul_x}, 32'd5);
    out_ready = 1'b1;
    step();
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_sum", {8'd0, sum}, 32'd0);
    step();
    chk("bp_fifth_x", {24'd0, mul_x}, 32'd10);
    chk("bp_fifth_y", {24'd0, mul_y}, 32'd11);

    // second partial pair, then reset between edges
    in_x = 8'd10; in_y = 8'd12;
    step();
    step();
    in_valid = 1'b0;
    step();
    chk("partial_sum", {8'd0, sum}, 32'd230);
    reset_ = 1'b0;
    #2;
    chk("midrst_sum", {8'd0, sum}, 32'd0);
    chk("midrst_mul_x", {24'd0, mul_x}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    #2;
    reset_ = 1'b1;
    step();
    set_pairs(8'd10, 8'd28, 8'd10, 8'd35, 8'd10, 8'd42, 8'd10, 8'd49);
    feed_group(-1, 0, cyc);
    chk("post_rst_latency", cyc, 32'd8);
    chk("post_rst_sum", {8'd0, sum}, 32'd1540);
    step();

    // N=1 instance: every pair is its own group
    b_in_x = 8'd20; b_in_y = 8'd49; b_in_valid = 1'b1;
    chk("n1_ready", {31'd0, b_in_ready}, 32'd1);
    step();
    b_in_valid = 1'b0;
    chk("n1_a_not_yet", {31'd0, b_out_valid}, 32'd0);
    step();
    chk("n1_a_valid", {31'd0, b_out_valid}, 32'd1);
    chk("n1_a_sum", {8'd0, b_sum}, 32'd980);
    step();
    chk("n1_a_drop", {31'd0, b_out_valid}, 32'd0);
    b_in_x = 8'd0; b_in_y = 8'd200; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    step();
    chk("n1_b_valid", {31'd0, b_out_valid}, 32'd1);
    chk("n1_b_sum", {8'd0, b_sum}, 32'd0);
    step();
    chk("n1_b_drop", {31'd0, b_out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
